// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store controller.
package lsu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RD_WAIT,
        ST_WR,
        ST_RESP
    } lsu_state_e;

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        if (is_store) begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end else begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      lane_i,
    input  logic [XLEN-1:0] word_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] load_data_o,
    output logic [XLEN-1:0] store_word_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Halfwords always come from lane 0 or 2; addr[0] is ignored here.
    always_comb begin
        byte_v = word_i[{lane_i, 3'b000} +: 8];
        half_v = word_i[{lane_i[1], 4'b0000} +: 16];

        case (funct3_i)
            F3_B:    load_data_o = {{24{byte_v[7]}}, byte_v};
            F3_BU:   load_data_o = {24'h000000, byte_v};
            F3_H:    load_data_o = {{16{half_v[15]}}, half_v};
            F3_HU:   load_data_o = {16'h0000, half_v};
            default: load_data_o = word_i;
        endcase

        store_word_o = word_i;
        case (funct3_i)
            F3_B:    store_word_o[{lane_i, 3'b000} +: 8]     = wdata_i[7:0];
            F3_H:    store_word_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            default: store_word_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller for a word-addressed memory without byte enables.
// Define LSU_ACCESS_CHECK_EN to reject misaligned and out-of-range accesses.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_AW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              mem_wren,
    output logic              mem_rden,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_d,
    input  logic [XLEN-1:0]   mem_q
);

    lsu_state_e        state_q;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [1:0]        lane_q;
    logic [XLEN-1:0]   wdata_q;

    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [XLEN-1:0]   rsp_rdata_q;
    logic              rsp_err_q;
    logic              mem_wren_q;
    logic              mem_rden_q;
    logic [MEM_AW-1:0] mem_addr_q;
    logic [XLEN-1:0]   mem_d_q;

    logic              req_err_d;
    logic [XLEN-1:0]   load_data_d;
    logic [XLEN-1:0]   store_word_d;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^req_addr[XLEN-1:MEM_AW+2];

    always_comb begin
        req_err_d = !f3_legal(req_we, req_funct3);
`ifdef LSU_ACCESS_CHECK_EN
        if (req_funct3[1:0] == 2'b01 && req_addr[0]) begin
            req_err_d = 1'b1;
        end
        if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) begin
            req_err_d = 1'b1;
        end
        if (|req_addr[XLEN-1:MEM_AW+2]) begin
            req_err_d = 1'b1;
        end
`endif
    end

    lsu_lane_align u_lane_align (
        .funct3_i     (f3_q),
        .lane_i       (lane_q),
        .word_i       (mem_q),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data_d),
        .store_word_o (store_word_d)
    );

    // Strobes default low each cycle so every one lasts exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            lane_q      <= 2'b00;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mem_wren_q  <= 1'b0;
            mem_rden_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_d_q     <= '0;
        end else begin
            mem_wren_q <= 1'b0;
            mem_rden_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready_q <= 1'b0;
                        we_q        <= req_we;
                        f3_q        <= req_funct3;
                        lane_q      <= req_addr[1:0];
                        wdata_q     <= req_wdata;
                        mem_addr_q  <= req_addr[MEM_AW+1:2];
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                        if (req_err_d) begin
                            rsp_err_q   <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= ST_RESP;
                        end else if (req_we && req_funct3 == F3_W) begin
                            mem_d_q    <= req_wdata;
                            mem_wren_q <= 1'b1;
                            state_q    <= ST_WR;
                        end else begin
                            mem_rden_q <= 1'b1;
                            state_q    <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    state_q <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (we_q) begin
                        mem_d_q    <= store_word_d;
                        mem_wren_q <= 1'b1;
                        state_q    <= ST_WR;
                    end else begin
                        rsp_rdata_q <= load_data_d;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end
                end
                ST_WR: begin
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_wren  = mem_wren_q;
    assign mem_rden  = mem_rden_q;
    assign mem_addr  = mem_addr_q;
    assign mem_d     = mem_d_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a small word-addressed memory model.
module tb_lsu_mem_ctrl;

    localparam int MEM_AW = 16;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              mem_wren;
    logic              mem_rden;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_d;
    logic [31:0]       mem_q;

    logic [31:0] mem [0:255];

    int n_tests = 0;
    int n_fail  = 0;

    int          r_rd, r_wr, r_rv, r_wrcnt;
    logic [31:0] r_rdata, r_d;
    logic        r_err, r_addr_ok, r_both;

    lsu_mem_ctrl #(.MEM_AW(MEM_AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_wren   (mem_wren),
        .mem_rden   (mem_rden),
        .mem_addr   (mem_addr),
        .mem_d      (mem_d),
        .mem_q      (mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wren) mem[mem_addr[7:0]] <= mem_d;
        if (mem_rden) mem_q <= mem[mem_addr[7:0]];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata);
        int w;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("req_ready_before_accept", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Cycle numbers count from the accept edge (cycle 0).
    task automatic run_txn(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
        logic [MEM_AW-1:0] exp_addr;
        exp_addr  = addr[MEM_AW+1:2];
        r_rd = 0; r_wr = 0; r_rv = 0; r_wrcnt = 0;
        r_rdata = 'x; r_d = 'x; r_err = 1'bx; r_addr_ok = 1'b1; r_both = 1'b0;
        accept(we, f3, addr, wdata);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (mem_rden && r_rd == 0) r_rd = c;
            if (mem_wren) begin
                if (r_wr == 0) r_wr = c;
                r_wrcnt++;
                r_d = mem_d;
            end
            if (mem_rden && mem_wren) r_both = 1'b1;
            if (mem_addr !== exp_addr) r_addr_ok = 1'b0;
            if (rsp_valid) begin
                r_rv    = c;
                r_rdata = rsp_rdata;
                r_err   = rsp_err;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_load(input string tag, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] exp);
        run_txn(1'b0, f3, addr, 32'h0);
        chk(tag, r_rdata, exp);
        chk({tag, "_rv_cycle"}, r_rv, 32'd3);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        rsp_ready  = 1'b0;

        #2;
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err",   {31'b0, rsp_err}, 32'd0);
        chk("rst_mem_wren",  {31'b0, mem_wren}, 32'd0);
        chk("rst_mem_rden",  {31'b0, mem_rden}, 32'd0);
        chk("rst_mem_addr",  {16'b0, mem_addr}, 32'h0);
        chk("rst_mem_d",     mem_d, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;

        // SW then LW
        run_txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        chk("sw_wren_cycle", r_wr, 32'd1);
        chk("sw_no_rden", r_rd, 32'd0);
        chk("sw_rv_cycle", r_rv, 32'd2);
        chk("sw_wr_count", r_wrcnt, 32'd1);
        chk("sw_mem_word4", mem[4], 32'hDEADBEEF);
        chk("sw_rdata_zero", r_rdata, 32'h0);
        chk("sw_err", {31'b0, r_err}, 32'd0);
        run_txn(1'b0, 3'b010, 32'h10, 32'h0);
        chk("lw_rden_cycle", r_rd, 32'd1);
        chk("lw_rv_cycle", r_rv, 32'd3);
        chk("lw_rdata", r_rdata, 32'hDEADBEEF);
        chk("lw_no_wren", r_wrcnt, 32'd0);
        chk("lw_addr_held", {31'b0, r_addr_ok}, 32'd1);

        // SB read-modify-write
        run_txn(1'b1, 3'b010, 32'h10, 32'h11223344);
        run_txn(1'b1, 3'b000, 32'h13, 32'h000000AA);
        chk("sb_rden_cycle", r_rd, 32'd1);
        chk("sb_wren_cycle", r_wr, 32'd3);
        chk("sb_rv_cycle", r_rv, 32'd4);
        chk("sb_mem_d", r_d, 32'hAA223344);
        chk("sb_mem_word4", mem[4], 32'hAA223344);
        chk("sb_addr_held", {31'b0, r_addr_ok}, 32'd1);
        chk("sb_no_overlap", {31'b0, r_both}, 32'd0);

        // Load extraction
        run_txn(1'b1, 3'b010, 32'h10, 32'h80FF7F01);
        check_load("lb_0x11",  3'b000, 32'h11, 32'h0000007F);
        check_load("lb_0x12",  3'b000, 32'h12, 32'hFFFFFFFF);
        check_load("lhu_0x12", 3'b101, 32'h12, 32'h000080FF);
        check_load("lh_0x12",  3'b001, 32'h12, 32'hFFFF80FF);
        check_load("lbu_0x13", 3'b100, 32'h13, 32'h00000080);
        check_load("lh_0x10",  3'b001, 32'h10, 32'h00007F01);

        // SH into upper half
        run_txn(1'b1, 3'b001, 32'h12, 32'h1234BEEF);
        chk("sh_wren_cycle", r_wr, 32'd3);
        chk("sh_rv_cycle", r_rv, 32'd4);
        chk("sh_mem_word4", mem[4], 32'hBEEF7F01);

        // Backpressure on the response channel
        rsp_ready = 1'b0;
        accept(1'b0, 3'b010, 32'h10, 32'h0);
        for (int c = 0; c < 10 && !rsp_valid; c++) @(negedge clk);
        chk("hold_rv_seen", {31'b0, rsp_valid}, 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("hold_rsp_rdata", rsp_rdata, 32'hBEEF7F01);
            chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_req_ready", {31'b0, req_ready}, 32'd1);
        chk("release_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check_load("after_hold_lw", 3'b010, 32'h10, 32'hBEEF7F01);

        // Illegal funct3
        run_txn(1'b0, 3'b011, 32'h10, 32'h0);
        chk("bad_load_err", {31'b0, r_err}, 32'd1);
        chk("bad_load_rv_cycle", r_rv, 32'd1);
        chk("bad_load_no_strobe", r_rd + r_wr, 32'd0);
        run_txn(1'b1, 3'b100, 32'h10, 32'h12345678);
        chk("bad_store_err", {31'b0, r_err}, 32'd1);
        chk("bad_store_no_strobe", r_rd + r_wr, 32'd0);
        chk("bad_store_rdata", r_rdata, 32'h0);
        chk("bad_store_mem_word4", mem[4], 32'hBEEF7F01);

        // Misaligned and out-of-range accesses
`ifdef LSU_ACCESS_CHECK_EN
        run_txn(1'b0, 3'b010, 32'h11, 32'h0);
        chk("lw_0x11_err", {31'b0, r_err}, 32'd1);
        chk("lw_0x11_rv_cycle", r_rv, 32'd1);
        chk("lw_0x11_no_strobe", r_rd + r_wr, 32'd0);
        run_txn(1'b0, 3'b001, 32'h13, 32'h0);
        chk("lh_0x13_err", {31'b0, r_err}, 32'd1);
        run_txn(1'b0, 3'b010, 32'h0004_0010, 32'h0);
        chk("lw_hi_addr_err", {31'b0, r_err}, 32'd1);
`else
        check_load("lw_0x11", 3'b010, 32'h11, 32'hBEEF7F01);
        check_load("lh_0x13", 3'b001, 32'h13, 32'hFFFFBEEF);
        check_load("lw_hi_addr", 3'b010, 32'h0004_0010, 32'hBEEF7F01);
`endif

        // Reset during the WR cycle of an SH
        accept(1'b1, 3'b001, 32'h10, 32'h00005555);
        for (int c = 1; c <= 3; c++) @(negedge clk);
        chk("rst_sh_wren_before", {31'b0, mem_wren}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_sh_wren_drop", {31'b0, mem_wren}, 32'd0);
        chk("rst_sh_rden_drop", {31'b0, mem_rden}, 32'd0);
        chk("rst_sh_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_sh_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_sh_mem_word4", mem[4], 32'hBEEF7F01);
        @(posedge clk);
        #1;
        check_load("rst_sh_lw", 3'b010, 32'h10, 32'hBEEF7F01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
